// File: rtl/cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cmult_pipe
//  Purpose  : Pipelined signed fixed-point complex multiplier with valid/ready
//             flow control, optional conjugation of operand B, selectable
//             truncate / round-half-up scaling and output saturation.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    Q          fractional bits of every operand and result (1 <= Q <= N-2)
//    N          total signed word width (N >= 4)
//  Ports
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_valid   input beat valid           in_ready   block can accept a beat
//    ar, ai     operand A real / imag      br, bi     operand B real / imag
//    conj_b     1 = multiply by conj(B)    rnd_en     1 = round, 0 = floor
//    out_valid  result valid               out_ready  downstream accepts
//    pr, pi     product real / imag        ovf        pr or pi saturated
// ----------------------------------------------------------------------------
//  Pipeline: S1 operands -> S2 products -> S3 wide sums -> output registers
//  (scale + saturate). A single global enable stalls every register at once.
// ============================================================================
module cmult_pipe #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ai,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bi,
    input  logic         conj_b,
    input  logic         rnd_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pr,
    output logic [N-1:0] pi,
    output logic         ovf
);

    localparam int c_PW = 2 * N;       // full product width
    localparam int c_SW = 2 * N + 1;   // sum width, holds any sum of two products

    // 2^(Q-1) at sum width, added before the shift for round-half-up
    localparam logic [c_SW-1:0] c_HALF = {{(c_SW-1){1'b0}}, 1'b1} << (Q - 1);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [c_SW-1:0] sx(input logic [c_PW-1:0] p);
        return {p[c_PW-1], p};
    endfunction

    // Returns {ovf, value}: optional rounding, arithmetic shift by Q, clamp.
    function automatic logic [N:0] scale_sat(input logic [c_SW-1:0] s,
                                             input logic            rnd);
        logic [c_SW-1:0] biased;
        logic [c_SW-1:0] sh;
        biased = s + (rnd ? c_HALF : {c_SW{1'b0}});
        sh     = c_SW'($signed(biased) >>> Q);
        // In range exactly when all bits from N-1 upward agree with the sign
        if ((&sh[c_SW-1:N-1]) || !(|sh[c_SW-1:N-1])) begin
            return {1'b0, sh[N-1:0]};
        end
        return {1'b1, sh[c_SW-1], {(N-1){~sh[c_SW-1]}}};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
    logic [N-1:0]    s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
    logic            s1_conj_q, s1_conj_d, s1_rnd_q, s1_rnd_d;

    logic            s2_valid_q, s2_valid_d;
    logic [c_PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
    logic [c_PW-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
    logic            s2_conj_q, s2_conj_d, s2_rnd_q, s2_rnd_d;

    logic            s3_valid_q, s3_valid_d;
    logic [c_SW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
    logic            s3_rnd_q, s3_rnd_d;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    pr_q, pr_d, pi_q, pi_d;
    logic            ovf_q, ovf_d;

    logic            w_en;
    logic [N:0]      w_re_sat;
    logic [N:0]      w_im_sat;

    // The whole pipe moves only when the output register is free or draining
    assign w_en     = !out_valid_q || out_ready;
    assign in_ready = w_en;

    assign w_re_sat = scale_sat(s3_re_q, s3_rnd_q);
    assign w_im_sat = scale_sat(s3_im_q, s3_rnd_q);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ar_d     = s1_ar_q;
        s1_ai_d     = s1_ai_q;
        s1_br_d     = s1_br_q;
        s1_bi_d     = s1_bi_q;
        s1_conj_d   = s1_conj_q;
        s1_rnd_d    = s1_rnd_q;
        s2_valid_d  = s2_valid_q;
        s2_rr_d     = s2_rr_q;
        s2_ii_d     = s2_ii_q;
        s2_ri_d     = s2_ri_q;
        s2_ir_d     = s2_ir_q;
        s2_conj_d   = s2_conj_q;
        s2_rnd_d    = s2_rnd_q;
        s3_valid_d  = s3_valid_q;
        s3_re_d     = s3_re_q;
        s3_im_d     = s3_im_q;
        s3_rnd_d    = s3_rnd_q;
        out_valid_d = out_valid_q;
        pr_d        = pr_q;
        pi_d        = pi_q;
        ovf_d       = ovf_q;

        if (w_en) begin
            // S1: capture the beat (or a bubble when in_valid is low)
            s1_valid_d  = in_valid;
            s1_ar_d     = ar;
            s1_ai_d     = ai;
            s1_br_d     = br;
            s1_bi_d     = bi;
            s1_conj_d   = conj_b;
            s1_rnd_d    = rnd_en;

            // S2: four full-width signed partial products
            s2_valid_d  = s1_valid_q;
            s2_rr_d     = c_PW'($signed(s1_ar_q)) * c_PW'($signed(s1_br_q));
            s2_ii_d     = c_PW'($signed(s1_ai_q)) * c_PW'($signed(s1_bi_q));
            s2_ri_d     = c_PW'($signed(s1_ar_q)) * c_PW'($signed(s1_bi_q));
            s2_ir_d     = c_PW'($signed(s1_ai_q)) * c_PW'($signed(s1_br_q));
            s2_conj_d   = s1_conj_q;
            s2_rnd_d    = s1_rnd_q;

            // S3: lossless sums; conjugation flips the sign of every bi term
            s3_valid_d  = s2_valid_q;
            s3_re_d     = s2_conj_q ? (sx(s2_rr_q) + sx(s2_ii_q))
                                    : (sx(s2_rr_q) - sx(s2_ii_q));
            s3_im_d     = s2_conj_q ? (sx(s2_ir_q) - sx(s2_ri_q))
                                    : (sx(s2_ri_q) + sx(s2_ir_q));
            s3_rnd_d    = s2_rnd_q;

            // Output: scale, saturate, register
            out_valid_d = s3_valid_q;
            pr_d        = w_re_sat[N-1:0];
            pi_d        = w_im_sat[N-1:0];
            ovf_d       = w_re_sat[N] | w_im_sat[N];
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ar_q     <= '0;
            s1_ai_q     <= '0;
            s1_br_q     <= '0;
            s1_bi_q     <= '0;
            s1_conj_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_rr_q     <= '0;
            s2_ii_q     <= '0;
            s2_ri_q     <= '0;
            s2_ir_q     <= '0;
            s2_conj_q   <= 1'b0;
            s2_rnd_q    <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_re_q     <= '0;
            s3_im_q     <= '0;
            s3_rnd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            pr_q        <= '0;
            pi_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ar_q     <= s1_ar_d;
            s1_ai_q     <= s1_ai_d;
            s1_br_q     <= s1_br_d;
            s1_bi_q     <= s1_bi_d;
            s1_conj_q   <= s1_conj_d;
            s1_rnd_q    <= s1_rnd_d;
            s2_valid_q  <= s2_valid_d;
            s2_rr_q     <= s2_rr_d;
            s2_ii_q     <= s2_ii_d;
            s2_ri_q     <= s2_ri_d;
            s2_ir_q     <= s2_ir_d;
            s2_conj_q   <= s2_conj_d;
            s2_rnd_q    <= s2_rnd_d;
            s3_valid_q  <= s3_valid_d;
            s3_re_q     <= s3_re_d;
            s3_im_q     <= s3_im_d;
            s3_rnd_q    <= s3_rnd_d;
            out_valid_q <= out_valid_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pr        = pr_q;
    assign pi        = pi_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmult_pipe
//  Purpose  : Scoreboard bench for cmult_pipe (Q=8, N=16). A driver pushes
//             hand-computed expected results as beats are accepted; a monitor
//             pops and compares whenever a result transfers, and watches
//             stall behaviour.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_cmult_pipe;

    localparam int Q = 8;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  ar = '0, ai = '0, br = '0, bi = '0;
    logic          conj_b = 1'b0;
    logic          rnd_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  pr, pi;
    logic          ovf;

    cmult_pipe #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .conj_b    (conj_b),
        .rnd_en    (rnd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pr        (pr),
        .pi        (pi),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] ar, ai, br, bi;
        logic        cj, rn;
        logic [15:0] epr, epi;
        logic        eovf;
    } vec_t;

    typedef struct {
        logic [15:0] epr, epi;
        logic        eovf;
        int          acc;
        bit          lat;
    } exp_t;

    vec_t vt [16];
    exp_t sb [$];
    int   nchk = 0;
    int   nerr = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Present a beat at the next falling edge and hold it until accepted.
    task automatic send(input int idx, input bit lat);
        int   g;
        exp_t e;
        @(negedge clk);
        ar = vt[idx].ar; ai = vt[idx].ai; br = vt[idx].br; bi = vt[idx].bi;
        conj_b = vt[idx].cj; rnd_en = vt[idx].rn; in_valid = 1'b1;
        #1;
        g = 0;
        while (in_ready !== 1'b1) begin
            g++;
            if (g > 1000) begin
                nchk++; nerr++;
                $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
                return;
            end
            @(negedge clk); #1;
        end
        e.epr = vt[idx].epr; e.epi = vt[idx].epi; e.eovf = vt[idx].eovf;
        e.acc = cyc + 1; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    // Monitor: compares transfers, checks stall behaviour
    initial begin
        exp_t        e;
        bit          stalled = 1'b0;
        logic [15:0] hpr = '0, hpi = '0;
        logic        hovf = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst || out_valid !== 1'b1) begin
                stalled = 1'b0;
            end else if (out_ready !== 1'b1) begin
                chk("stall_in_ready", in_ready, 0);
                if (stalled) chk("stall_hold", {pr, pi, ovf}, {hpr, hpi, hovf});
                stalled = 1'b1;
                hpr = pr; hpi = pi; hovf = ovf;
            end else begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_out: pr=%h pi=%h with empty scoreboard", pr, pi);
                end else begin
                    e = sb.pop_front();
                    chk("result pr,pi,ovf", {pr, pi, ovf}, {e.epr, e.epi, e.eovf});
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    initial begin
        //         ar        ai        br        bi        cj    rn    pr        pi        ovf
        vt[0]  = '{16'h0080, 16'h0000, 16'h0180, 16'h0000, 1'b0, 1'b0, 16'h00C0, 16'h0000, 1'b0};
        vt[1]  = '{16'hFE80, 16'h0000, 16'hFC80, 16'h0000, 1'b0, 1'b0, 16'h0540, 16'h0000, 1'b0};
        vt[2]  = '{16'h0080, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[3]  = '{16'hFC80, 16'h0000, 16'hFC80, 16'h0000, 1'b0, 1'b0, 16'h0C40, 16'h0000, 1'b0};
        vt[4]  = '{16'hFE80, 16'h0000, 16'h0180, 16'h0000, 1'b0, 1'b0, 16'hFDC0, 16'h0000, 1'b0};
        vt[5]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0200, 1'b0};
        vt[6]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0};
        vt[7]  = '{16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[8]  = '{16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0};
        vt[9]  = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
        vt[10] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vt[11] = '{16'h6400, 16'h0000, 16'h6400, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1};
        vt[12] = '{16'h6400, 16'h0000, 16'h9C00, 16'h0000, 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1};
        vt[13] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0};
        vt[14] = '{16'h6400, 16'h0000, 16'h0000, 16'h6400, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 1'b1};
        vt[15] = '{16'h0100, 16'h0000, 16'h0000, 16'h0200, 1'b1, 1'b0, 16'h0000, 16'hFE00, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pr", pr, 0);
        chk("rst_pi", pi, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Back-to-back directed vectors with latency checks
        for (int i = 0; i < 16; i++) send(i, 1'b1);
        idle();
        drain("drain_directed");

        // Six beats with a 4-cycle mid-stream stall
        fork
            begin
                for (int i = 0; i < 6; i++) send(i, 1'b0);
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Random bubbles and backpressure over the directed vector set
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 2000; n++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        repeat (gap - 1) @(negedge clk);
                    end
                    send($urandom_range(0, 15), 1'b0);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        // Asynchronous reset with beats in flight and one held at the output
        for (int i = 1; i < 5; i++) send(i, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pr", pr, 0);
        chk("midrst_pi", pi, 0);
        chk("midrst_ovf", ovf, 0);
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        send(6, 1'b1);
        idle();
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
